// File: rtl/fetch_stage_pkg.sv
// Shared constants and fetch FSM state encoding for the instruction-fetch stage.
package fetch_stage_pkg;

  localparam logic [31:0] NOP_INST = 32'h0000_0013;
  localparam int unsigned PC_INC   = 4;

  typedef logic [1:0] fetch_state_t;

  localparam fetch_state_t ST_FETCH = 2'd0;
  localparam fetch_state_t ST_HOLD  = 2'd1;
  localparam fetch_state_t ST_DROP  = 2'd2;

endpackage

// File: rtl/fetch_stage_if_id_reg.sv
// Generic pipeline register holding pc/inst/valid with load, hold and flush-to-bubble.
module if_id_reg
  import fetch_stage_pkg::*;
#(
  parameter int N = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic         flush,
  input  logic [N-1:0] pc_d,
  input  logic [N-1:0] inst_d,
  output logic [N-1:0] pc,
  output logic [N-1:0] inst,
  output logic         valid
);

  // flush wins over load; pc is left as-is on a bubble since nothing consumes it
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc    <= '0;
      inst  <= N'(NOP_INST);
      valid <= 1'b0;
    end else if (flush) begin
      inst  <= N'(NOP_INST);
      valid <= 1'b0;
    end else if (load) begin
      pc    <= pc_d;
      inst  <= inst_d;
      valid <= 1'b1;
    end
  end

endmodule

// File: rtl/fetch_stage.sv
// Instruction-fetch stage: PC, single-outstanding imem requests, stall/redirect handling.
//
// state    | meaning
// ST_FETCH | request outstanding at pc
// ST_HOLD  | response captured in hold buffer while decode is stalled, no request
// ST_DROP  | stale request (buf_pc) still in flight after a redirect; its data is discarded
module fetch_stage
  import fetch_stage_pkg::*;
#(
  parameter int          N        = 32,
  parameter logic [N-1:0] RESET_PC = '0
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         stall,
  input  logic         branch_taken,
  input  logic [N-1:0] branch_target,
  output logic         imem_req,
  output logic [N-1:0] imem_addr,
  input  logic         imem_ready,
  input  logic [N-1:0] imem_rdata,
  output logic [N-1:0] if_id_pc,
  output logic [N-1:0] if_id_inst,
  output logic         if_id_valid
);

  fetch_state_t state, state_d;
  logic [N-1:0] pc, pc_d, pc_inc, redirect_pc;
  logic [N-1:0] buf_pc, buf_pc_d, buf_inst, buf_inst_d;
  logic         ld, fl;
  logic [N-1:0] ld_pc, ld_inst;
  logic         unused_tgt_bits;

  assign unused_tgt_bits = ^branch_target[1:0];
  assign pc_inc          = pc + N'(PC_INC);
  assign redirect_pc     = {branch_target[N-1:2], 2'b00};

  assign imem_req  = !rst && (state != ST_HOLD);
  assign imem_addr = (state == ST_DROP) ? buf_pc : pc;

  always_comb begin
    state_d    = state;
    pc_d       = pc;
    buf_pc_d   = buf_pc;
    buf_inst_d = buf_inst;
    ld         = 1'b0;
    fl         = 1'b0;
    ld_pc      = pc;
    ld_inst    = imem_rdata;
    if (branch_taken) begin
      fl   = 1'b1;
      pc_d = redirect_pc;
      // a request still in flight must be drained before fetching the target
      if (state == ST_FETCH && !imem_ready) begin
        state_d  = ST_DROP;
        buf_pc_d = pc;
      end else if (state == ST_DROP && !imem_ready) begin
        state_d = ST_DROP;
      end else begin
        state_d = ST_FETCH;
      end
    end else begin
      case (state)
        ST_FETCH: begin
          if (imem_ready) begin
            if (stall) begin
              buf_pc_d   = pc;
              buf_inst_d = imem_rdata;
              state_d    = ST_HOLD;
            end else begin
              ld   = 1'b1;
              pc_d = pc_inc;
            end
          end else if (!stall) begin
            fl = 1'b1;
          end
        end
        ST_HOLD: begin
          if (!stall) begin
            ld      = 1'b1;
            ld_pc   = buf_pc;
            ld_inst = buf_inst;
            pc_d    = pc_inc;
            state_d = ST_FETCH;
          end
        end
        ST_DROP: begin
          if (!stall) fl = 1'b1;
          if (imem_ready) state_d = ST_FETCH;
        end
        default: state_d = ST_FETCH;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= ST_FETCH;
      pc       <= RESET_PC;
      buf_pc   <= '0;
      buf_inst <= '0;
    end else begin
      state    <= state_d;
      pc       <= pc_d;
      buf_pc   <= buf_pc_d;
      buf_inst <= buf_inst_d;
    end
  end

  if_id_reg #(.N(N)) u_if_id (
    .clk   (clk),
    .rst   (rst),
    .load  (ld),
    .flush (fl),
    .pc_d  (ld_pc),
    .inst_d(ld_inst),
    .pc    (if_id_pc),
    .inst  (if_id_inst),
    .valid (if_id_valid)
  );

endmodule
